fml_txn_recorder: RTL and testbench

Parametrised memory-transaction recorder for the formal/simulation checker environment. It observes the coprocessor memory bus and frames transactions by instruction: issue is the cpu_req/ack handshake, retirement is the cop_rsp/ack handshake. Each instruction's transactions, up to TXN_SLOTS, are captured with their responses. A registered snapshot is published with a one-cycle `vtx_valid` pulse, replacing the fixed four-transaction port bundle fed to checker modules.

---
 rtl/fml_txn_recorder_pkg.sv | 25 ++
 rtl/fml_txn_recorder_if.sv | 33 +++
 rtl/fml_txn_recorder_slot_buf.sv | 40 ++++
 rtl/fml_txn_recorder.sv | 180 ++++++++++++++++++
 tb/tb_fml_txn_recorder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fml_txn_recorder_pkg.sv
// Shared types for the memory-transaction recorder: FSM encoding, slot record, slot limit.
// vtx_txn_t is sized for the default 32-bit bus; parametrised users pass a width-matched copy.
package fml_vtx_pkg;

   localparam int VTX_MAX_SLOTS = 16;
   localparam int VTX_AW        = 32;
   localparam int VTX_DW        = 32;
   localparam int VTX_BW        = VTX_DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } vtx_state_e;

   typedef struct packed {
      logic              wen;
      logic [VTX_AW-1:0] addr;
      logic [VTX_DW-1:0] wdata;
      logic [VTX_DW-1:0] rdata;
      logic [VTX_BW-1:0] ben;
      logic              error;
   } vtx_txn_t;

endpackage

// File: rtl/fml_txn_recorder_if.sv
// Observed coprocessor bus: issue/retire handshakes plus the memory request/response channel.
interface fml_txn_recorder_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   localparam int BW = DW / 8;

   logic          cpu_req;
   logic          cpu_ack;
   logic          cop_rsp;
   logic          cop_ack;
   logic          mem_cen;
   logic          mem_stall;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_ben;
   logic [DW-1:0] mem_rdata;
   logic          mem_error;

   modport master (
      output cpu_req, cpu_ack, cop_rsp, cop_ack,
      output mem_cen, mem_stall, mem_wen, mem_addr, mem_wdata, mem_ben,
      output mem_rdata, mem_error
   );

   modport slave (
      input cpu_req, cpu_ack, cop_rsp, cop_ack,
      input mem_cen, mem_stall, mem_wen, mem_addr, mem_wdata, mem_ben,
      input mem_rdata, mem_error
   );

endinterface

// File: rtl/fml_txn_recorder_slot_buf.sv
// Working buffer of per-instruction transaction slots; request and response halves are
// written independently since a response lands one cycle after its request.
module vtx_txn_slot_buf
   import fml_vtx_pkg::*;
#(
   parameter int  TXN_SLOTS = 4,
   parameter int  DW        = 32,
   parameter type txn_t     = vtx_txn_t,
   localparam int IW        = (TXN_SLOTS > 1) ? $clog2(TXN_SLOTS) : 1
) (
   input  logic          vtx_clk,
   input  logic          vtx_reset,
   input  logic          clear,
   input  logic          req_we,
   input  logic [IW-1:0] req_idx,
   input  txn_t          req_txn,
   input  logic          rsp_we,
   input  logic [IW-1:0] rsp_idx,
   input  logic [DW-1:0] rsp_rdata,
   input  logic          rsp_error,
   output txn_t          slot_q [TXN_SLOTS]
);

   // Later writes override the clear so an accept in the issue cycle survives.
   always_ff @(posedge vtx_clk) begin
      if (vtx_reset) begin
         for (int i = 0; i < TXN_SLOTS; i++) slot_q[i] <= '0;
      end else begin
         if (clear) begin
            for (int i = 0; i < TXN_SLOTS; i++) slot_q[i] <= '0;
         end
         if (req_we) slot_q[req_idx] <= req_txn;
         if (rsp_we) begin
            slot_q[rsp_idx].rdata <= rsp_rdata;
            slot_q[rsp_idx].error <= rsp_error;
         end
      end
   end

endmodule

// File: rtl/fml_txn_recorder.sv
// Frames memory transactions by instruction (issue..retire) and publishes a registered snapshot.
//   state    | meaning
//   ST_IDLE  | no instruction open; issue opens one and clears the working buffer
//   ST_BUSY  | instruction open; accepts are recorded until retire
//   ST_DRAIN | retired with an accept on the retire cycle; waiting one cycle for its response
module fml_txn_recorder
   import fml_vtx_pkg::*;
#(
   parameter int  TXN_SLOTS = 4,
   parameter int  AW        = 32,
   parameter int  DW        = 32,
   localparam int BW        = DW / 8,
   localparam int CW        = $clog2(TXN_SLOTS + 1),
   localparam int IW        = (TXN_SLOTS > 1) ? $clog2(TXN_SLOTS) : 1
) (
   input  logic                    vtx_clk,
   input  logic                    vtx_reset,
   fml_txn_recorder_if.slave       bus,
   output logic                    vtx_valid,
   output logic [CW-1:0]           vtx_txn_count,
   output logic                    vtx_txn_ovf,
   output logic [TXN_SLOTS-1:0]    vtx_mem_cen,
   output logic [TXN_SLOTS-1:0]    vtx_mem_wen,
   output logic [TXN_SLOTS*AW-1:0] vtx_mem_addr,
   output logic [TXN_SLOTS*DW-1:0] vtx_mem_wdata,
   output logic [TXN_SLOTS*DW-1:0] vtx_mem_rdata,
   output logic [TXN_SLOTS*BW-1:0] vtx_mem_ben,
   output logic [TXN_SLOTS-1:0]    vtx_mem_error,
   output logic                    vtx_protocol_err
);

   if (TXN_SLOTS < 1 || TXN_SLOTS > VTX_MAX_SLOTS) begin : g_slots_range
      $error("fml_txn_recorder: TXN_SLOTS out of range");
   end

   typedef struct packed {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic [BW-1:0] ben;
      logic          error;
   } txn_t;

   localparam logic [CW-1:0] SLOTS_C = CW'(TXN_SLOTS);

   vtx_state_e    state;
   logic [CW-1:0] count;
   logic          ovf;
   logic          rsp_pend;
   logic [IW-1:0] rsp_idx;

   logic          issue, retire, accept;
   logic          clear, take, store, publish;
   logic [CW-1:0] eff_count;
   txn_t          req_txn;
   txn_t          slot_q [TXN_SLOTS];
   txn_t          view   [TXN_SLOTS];

   always_comb begin
      issue     = bus.cpu_req & bus.cpu_ack;
      retire    = bus.cop_rsp & bus.cop_ack;
      accept    = bus.mem_cen & ~bus.mem_stall;
      clear     = (state == ST_IDLE) & issue;
      take      = accept & ((state == ST_BUSY) | clear);
      eff_count = clear ? '0 : count;
      store     = take & (eff_count < SLOTS_C);
      publish   = ((state == ST_BUSY) & retire & ~accept) | (state == ST_DRAIN);

      req_txn       = '0;
      req_txn.wen   = bus.mem_wen;
      req_txn.addr  = bus.mem_addr;
      req_txn.wdata = bus.mem_wdata;
      req_txn.ben   = bus.mem_ben;
   end

   // Publish happens on the same edge that writes a pending response, so bypass it in.
   always_comb begin
      view = slot_q;
      for (int i = 0; i < TXN_SLOTS; i++) begin
         if (rsp_pend && rsp_idx == IW'(i)) begin
            view[i].rdata = bus.mem_rdata;
            view[i].error = bus.mem_error;
         end
      end
   end

   vtx_txn_slot_buf #(
      .TXN_SLOTS (TXN_SLOTS),
      .DW        (DW),
      .txn_t     (txn_t)
   ) u_slot_buf (
      .vtx_clk   (vtx_clk),
      .vtx_reset (vtx_reset),
      .clear     (clear),
      .req_we    (store),
      .req_idx   (eff_count[IW-1:0]),
      .req_txn   (req_txn),
      .rsp_we    (rsp_pend),
      .rsp_idx   (rsp_idx),
      .rsp_rdata (bus.mem_rdata),
      .rsp_error (bus.mem_error),
      .slot_q    (slot_q)
   );

   always_ff @(posedge vtx_clk) begin
      if (vtx_reset) begin
         state            <= ST_IDLE;
         count            <= '0;
         ovf              <= 1'b0;
         rsp_pend         <= 1'b0;
         rsp_idx          <= '0;
         vtx_valid        <= 1'b0;
         vtx_txn_count    <= '0;
         vtx_txn_ovf      <= 1'b0;
         vtx_mem_cen      <= '0;
         vtx_mem_wen      <= '0;
         vtx_mem_addr     <= '0;
         vtx_mem_wdata    <= '0;
         vtx_mem_rdata    <= '0;
         vtx_mem_ben      <= '0;
         vtx_mem_error    <= '0;
         vtx_protocol_err <= 1'b0;
      end else begin
         vtx_valid <= publish;
         rsp_pend  <= store;
         rsp_idx   <= eff_count[IW-1:0];

         if (take) begin
            if (store) count <= eff_count + CW'(1);
            else       ovf   <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (issue) begin
                  state <= ST_BUSY;
                  ovf   <= 1'b0;
                  if (!store) count <= '0;
               end
               if ((accept & ~issue) | retire) vtx_protocol_err <= 1'b1;
            end
            ST_BUSY: begin
               if (issue) vtx_protocol_err <= 1'b1;
               if (retire) state <= accept ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               if (issue | accept) vtx_protocol_err <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (publish) begin
            vtx_txn_count <= count;
            vtx_txn_ovf   <= ovf;
            for (int i = 0; i < TXN_SLOTS; i++) begin
               if (CW'(i) < count) begin
                  vtx_mem_cen[i]              <= 1'b1;
                  vtx_mem_wen[i]              <= view[i].wen;
                  vtx_mem_addr[i*AW +: AW]    <= view[i].addr;
                  vtx_mem_wdata[i*DW +: DW]   <= view[i].wdata;
                  vtx_mem_rdata[i*DW +: DW]   <= view[i].rdata;
                  vtx_mem_ben[i*BW +: BW]     <= view[i].ben;
                  vtx_mem_error[i]            <= view[i].error;
               end else begin
                  vtx_mem_cen[i]              <= 1'b0;
                  vtx_mem_wen[i]              <= 1'b0;
                  vtx_mem_addr[i*AW +: AW]    <= '0;
                  vtx_mem_wdata[i*DW +: DW]   <= '0;
                  vtx_mem_rdata[i*DW +: DW]   <= '0;
                  vtx_mem_ben[i*BW +: BW]     <= '0;
                  vtx_mem_error[i]            <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fml_txn_recorder.sv
// Directed bench for fml_txn_recorder with TXN_SLOTS=4 and a 32-bit bus.
module tb_fml_txn_recorder;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int CW = $clog2(N + 1);

   logic vtx_clk   = 1'b0;
   logic vtx_reset = 1'b1;

   logic            vtx_valid;
   logic [CW-1:0]   vtx_txn_count;
   logic            vtx_txn_ovf;
   logic [N-1:0]    vtx_mem_cen;
   logic [N-1:0]    vtx_mem_wen;
   logic [N*AW-1:0] vtx_mem_addr;
   logic [N*DW-1:0] vtx_mem_wdata;
   logic [N*DW-1:0] vtx_mem_rdata;
   logic [N*BW-1:0] vtx_mem_ben;
   logic [N-1:0]    vtx_mem_error;
   logic            vtx_protocol_err;

   int checks = 0;
   int errors = 0;

   always #5 vtx_clk = ~vtx_clk;

   fml_txn_recorder_if #(.AW(AW), .DW(DW)) bus ();

   fml_txn_recorder #(.TXN_SLOTS(N), .AW(AW), .DW(DW)) dut (
      .vtx_clk          (vtx_clk),
      .vtx_reset        (vtx_reset),
      .bus              (bus),
      .vtx_valid        (vtx_valid),
      .vtx_txn_count    (vtx_txn_count),
      .vtx_txn_ovf      (vtx_txn_ovf),
      .vtx_mem_cen      (vtx_mem_cen),
      .vtx_mem_wen      (vtx_mem_wen),
      .vtx_mem_addr     (vtx_mem_addr),
      .vtx_mem_wdata    (vtx_mem_wdata),
      .vtx_mem_rdata    (vtx_mem_rdata),
      .vtx_mem_ben      (vtx_mem_ben),
      .vtx_mem_error    (vtx_mem_error),
      .vtx_protocol_err (vtx_protocol_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vtx_clk);
      #1;
   endtask

   // Junk response values make any capture in a non-response cycle visible.
   task automatic bus_idle();
      bus.cpu_req   = 1'b0;
      bus.cpu_ack   = 1'b0;
      bus.cop_rsp   = 1'b0;
      bus.cop_ack   = 1'b0;
      bus.mem_cen   = 1'b0;
      bus.mem_stall = 1'b0;
      bus.mem_wen   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_ben   = '0;
      bus.mem_rdata = 32'hBADBAD00;
      bus.mem_error = 1'b1;
   endtask

   task automatic acc(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] ben);
      bus.mem_cen   = 1'b1;
      bus.mem_wen   = wen;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_ben   = ben;
   endtask

   task automatic rsp(input logic [31:0] rdata, input logic err);
      bus.mem_rdata = rdata;
      bus.mem_error = err;
   endtask

   task automatic do_issue();
      bus.cpu_req = 1'b1;
      bus.cpu_ack = 1'b1;
   endtask

   task automatic do_retire();
      bus.cop_rsp = 1'b1;
      bus.cop_ack = 1'b1;
   endtask

   initial begin
      bus_idle();
      vtx_reset = 1'b1;
      tick();
      tick();
      chk("rst_valid", vtx_valid, 0);
      chk("rst_count", vtx_txn_count, 0);
      chk("rst_ovf", vtx_txn_ovf, 0);
      chk("rst_cen", vtx_mem_cen, 0);
      chk("rst_addr", vtx_mem_addr, 0);
      chk("rst_perr", vtx_protocol_err, 0);
      vtx_reset = 1'b0;
      tick();

      // Two transactions, retire after both responses
      bus_idle(); do_issue(); tick();
      bus_idle(); acc(0, 32'h1000, 32'h0, 4'hF); tick();
      bus_idle(); acc(1, 32'h2000, 32'hDEADBEEF, 4'hF); rsp(32'h11112222, 0); tick();
      bus_idle(); rsp(32'h33334444, 0); tick();
      chk("t1_no_early_valid", vtx_valid, 0);
      bus_idle(); do_retire(); tick();
      chk("t1_valid", vtx_valid, 1);
      chk("t1_count", vtx_txn_count, 2);
      chk("t1_ovf", vtx_txn_ovf, 0);
      chk("t1_cen", vtx_mem_cen, 4'b0011);
      chk("t1_wen", vtx_mem_wen, 4'b0010);
      chk("t1_addr", vtx_mem_addr, {32'h0, 32'h0, 32'h2000, 32'h1000});
      chk("t1_wdata", vtx_mem_wdata, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
      chk("t1_rdata", vtx_mem_rdata, {32'h0, 32'h0, 32'h33334444, 32'h11112222});
      chk("t1_ben", vtx_mem_ben, 16'h00FF);
      chk("t1_error", vtx_mem_error, 4'b0000);
      bus_idle(); tick();
      chk("t1_valid_pulse", vtx_valid, 0);
      chk("t1_hold_count", vtx_txn_count, 2);

      // Six accepts into four slots
      bus_idle(); do_issue(); tick();
      for (int k = 0; k < 6; k++) begin
         bus_idle();
         acc(0, 32'h100 + 32'(4 * k), 32'h0, 4'hF);
         if (k > 0) rsp(32'h50000000 + 32'(k - 1), 0);
         tick();
      end
      bus_idle(); rsp(32'h50000005, 0); tick();
      bus_idle(); do_retire(); tick();
      chk("t2_valid", vtx_valid, 1);
      chk("t2_count", vtx_txn_count, 4);
      chk("t2_ovf", vtx_txn_ovf, 1);
      chk("t2_cen", vtx_mem_cen, 4'b1111);
      chk("t2_addr", vtx_mem_addr, {32'h10C, 32'h108, 32'h104, 32'h100});
      chk("t2_rdata", vtx_mem_rdata, {32'h50000003, 32'h50000002, 32'h50000001, 32'h50000000});
      chk("t2_perr", vtx_protocol_err, 0);

      // Accept on the retire cycle, pending response also captured on retire
      bus_idle(); do_issue(); tick();
      bus_idle(); acc(1, 32'h3000, 32'h12345678, 4'h3); tick();
      bus_idle(); rsp(32'h77770000, 0); do_retire(); acc(0, 32'h4000, 32'h0, 4'hC); tick();
      chk("t3_no_valid_r1", vtx_valid, 0);
      bus_idle(); rsp(32'hCAFEF00D, 1); tick();
      chk("t3_valid_r2", vtx_valid, 1);
      chk("t3_count", vtx_txn_count, 2);
      chk("t3_ovf_cleared", vtx_txn_ovf, 0);
      chk("t3_addr", vtx_mem_addr, {32'h0, 32'h0, 32'h4000, 32'h3000});
      chk("t3_rdata", vtx_mem_rdata, {32'h0, 32'h0, 32'hCAFEF00D, 32'h77770000});
      chk("t3_error", vtx_mem_error, 4'b0010);
      chk("t3_wen", vtx_mem_wen, 4'b0001);
      chk("t3_ben", vtx_mem_ben, 16'h00C3);
      bus_idle(); tick();
      chk("t3_valid_pulse", vtx_valid, 0);

      // Stalled request held for three cycles
      bus_idle(); do_issue(); tick();
      for (int k = 0; k < 3; k++) begin
         bus_idle(); acc(0, 32'h5000, 32'h0, 4'hF); bus.mem_stall = 1'b1; tick();
      end
      bus_idle(); acc(0, 32'h5004, 32'h0, 4'hF); tick();
      bus_idle(); rsp(32'h600DD00D, 0); do_retire(); tick();
      chk("t4_valid", vtx_valid, 1);
      chk("t4_count", vtx_txn_count, 1);
      chk("t4_cen", vtx_mem_cen, 4'b0001);
      chk("t4_addr", vtx_mem_addr, {96'h0, 32'h5004});
      chk("t4_rdata", vtx_mem_rdata, {96'h0, 32'h600DD00D});

      // Protocol violations in IDLE, then an accept in the issue cycle
      bus_idle(); acc(0, 32'h6000, 32'h0, 4'hF); tick();
      chk("t5_perr_acc", vtx_protocol_err, 1);
      chk("t5_no_valid_a", vtx_valid, 0);
      bus_idle(); do_retire(); tick();
      chk("t5_perr_ret", vtx_protocol_err, 1);
      chk("t5_no_valid_b", vtx_valid, 0);
      chk("t5_hold_addr", vtx_mem_addr, {96'h0, 32'h5004});
      bus_idle(); do_issue(); acc(0, 32'h7000, 32'h0, 4'hF); tick();
      bus_idle(); rsp(32'hABCD0001, 0); do_retire(); tick();
      chk("t5_valid", vtx_valid, 1);
      chk("t5_count", vtx_txn_count, 1);
      chk("t5_addr", vtx_mem_addr, {96'h0, 32'h7000});
      chk("t5_rdata", vtx_mem_rdata, {96'h0, 32'hABCD0001});
      chk("t5_perr_sticky", vtx_protocol_err, 1);

      // Reset mid-instruction
      bus_idle(); do_issue(); tick();
      bus_idle(); acc(0, 32'h8000, 32'h0, 4'hF); tick();
      bus_idle(); acc(0, 32'h8004, 32'h0, 4'hF); rsp(32'h1, 0); tick();
      bus_idle(); vtx_reset = 1'b1; tick();
      chk("t6_valid", vtx_valid, 0);
      chk("t6_count", vtx_txn_count, 0);
      chk("t6_cen", vtx_mem_cen, 0);
      chk("t6_addr", vtx_mem_addr, 0);
      chk("t6_rdata", vtx_mem_rdata, 0);
      chk("t6_perr", vtx_protocol_err, 0);
      vtx_reset = 1'b0;
      bus_idle(); do_retire(); tick();
      chk("t6_no_publish", vtx_valid, 0);
      bus_idle(); tick();
      bus_idle(); do_issue(); tick();
      bus_idle(); acc(0, 32'h9000, 32'h0, 4'hF); tick();
      bus_idle(); rsp(32'h99990000, 0); tick();
      bus_idle(); do_retire(); tick();
      chk("t6_new_valid", vtx_valid, 1);
      chk("t6_new_count", vtx_txn_count, 1);
      chk("t6_new_cen", vtx_mem_cen, 4'b0001);
      chk("t6_new_addr", vtx_mem_addr, {96'h0, 32'h9000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
